// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock on a shared shift/add datapath.
// Supports circular rotation, sin/cos generation and vectoring, with quadrant pre-rotation and guard bits.
module cordic_iter_engine #(
    parameter int WID   = 32,
    parameter int ITER  = 24,
    parameter int GUARD = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     mode,
    input  logic [WID-1:0] x_in,
    input  logic [WID-1:0] y_in,
    input  logic [WID-1:0] z_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WID-1:0] x_out,
    output logic [WID-1:0] y_out,
    output logic [WID-1:0] z_out,
    output logic           busy
);

    // X/Y carry two extra integer bits so the CORDIC gain on near-full-scale inputs
    // cannot wrap before the final saturation.
    localparam int XW  = WID + GUARD + 2;
    localparam int ZW  = WID + GUARD;
    localparam int RW  = XW - GUARD + 1;
    localparam int CW  = $clog2(ITER + 1);
    localparam int RND = (1 << GUARD) >> 1;

    localparam real    PI        = 3.14159265358979323846;
    localparam real    ANG_SCALE = (2.0 ** (WID - 1)) / PI;
    localparam longint K_VAL     = longint'(0.607252935 * (2.0 ** (WID - 2)));

    localparam logic signed [XW-1:0] K_LOAD = XW'(K_VAL) <<< GUARD;
    localparam logic [ZW-1:0]        PI_Z   = {1'b1, {(ZW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

    state_t                 state, state_d;
    logic                   rst_done;
    logic                   is_vec, is_sincos;
    logic [WID-1:0]         x_q, y_q, z_q;
    logic signed [XW-1:0]   x_w, y_w;
    logic [ZW-1:0]          z_w;
    logic [CW-1:0]          cnt;

    logic signed [XW-1:0]   x_pre, y_pre, x_sh, y_sh, x_n, y_n;
    logic [ZW-1:0]          z_pre, z_n, atan_i;
    logic                   dir;

    // Arctangent table in guard-extended angle units; the extra last entry is never used.
    logic [ZW-1:0] atan_tab [0:ITER];
    for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
        localparam longint ATAN_VAL = longint'($atan(1.0 / (2.0 ** gi)) * ANG_SCALE);
        assign atan_tab[gi] = ZW'(ATAN_VAL) << GUARD;
    end
    assign atan_tab[ITER] = '0;

    function automatic logic [WID-1:0] round_sat(input logic signed [XW-1:0] v);
        logic signed [XW:0]   s;
        logic signed [RW-1:0] r;
        s = XW'(v) + (XW+1)'(RND);
        s = $signed({v[XW-1], v}) + (XW+1)'(RND);
        r = RW'(s >>> GUARD);
        if (r[RW-1:WID-1] == {(RW-WID+1){r[RW-1]}})
            return r[WID-1:0];
        return r[RW-1] ? {1'b1, {(WID-1){1'b0}}} : {1'b0, {(WID-1){1'b1}}};
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        in_ready  = (state == S_IDLE) && rst_done;
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
        unique case (state)
            S_IDLE:  if (in_valid && in_ready) state_d = S_PRE;
            S_PRE:   state_d = S_ITER;
            S_ITER:  if (cnt == CW'(ITER)) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand load with quadrant pre-rotation into the +/-pi/2 convergence range.
    always_comb begin
        x_pre = XW'($signed(x_q)) <<< GUARD;
        y_pre = XW'($signed(y_q)) <<< GUARD;
        z_pre = ZW'(z_q) << GUARD;
        if (is_sincos) begin
            x_pre = K_LOAD;
            y_pre = '0;
        end
        if (is_vec) begin
            z_pre = '0;
            if (x_pre[XW-1]) begin
                x_pre = -x_pre;
                y_pre = -y_pre;
                z_pre = PI_Z;
            end
        end else if (z_q[WID-1] != z_q[WID-2]) begin
            x_pre = -x_pre;
            y_pre = -y_pre;
            z_pre = z_pre ^ PI_Z;
        end
    end

    // One micro-rotation; a zero vector in vectoring has no direction, so it is held.
    always_comb begin
        x_sh   = x_w >>> cnt;
        y_sh   = y_w >>> cnt;
        atan_i = atan_tab[cnt];
        dir    = is_vec ? ~y_w[XW-1] : z_w[ZW-1];
        x_n    = x_w;
        y_n    = y_w;
        z_n    = z_w;
        if (!(is_vec && x_w == '0 && y_w == '0)) begin
            if (!dir) begin
                x_n = x_w - y_sh;
                y_n = y_w + x_sh;
                z_n = z_w - atan_i;
            end else begin
                x_n = x_w + y_sh;
                y_n = y_w - x_sh;
                z_n = z_w + atan_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values;
    // all registers (outputs included) are cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rst_done  <= 1'b0;
            is_vec    <= 1'b0;
            is_sincos <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            x_w       <= '0;
            y_w       <= '0;
            z_w       <= '0;
            cnt       <= '0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else begin
            state    <= state_d;
            rst_done <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        is_vec    <= (mode == 2'b10);
                        is_sincos <= (mode == 2'b01);
                        x_q       <= x_in;
                        y_q       <= y_in;
                        z_q       <= z_in;
                    end
                end
                S_PRE: begin
                    x_w <= x_pre;
                    y_w <= y_pre;
                    z_w <= z_pre;
                    cnt <= '0;
                end
                S_ITER: begin
                    if (cnt != CW'(ITER)) begin
                        x_w <= x_n;
                        y_w <= y_n;
                        z_w <= z_n;
                        cnt <= cnt + 1'b1;
                    end else begin
                        x_out <= round_sat(x_w);
                        y_out <= round_sat(y_w);
                        z_out <= WID'((z_w + ZW'(RND)) >> GUARD);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed self-checking bench for cordic_iter_engine (WID=32, ITER=24, GUARD=2).
// Expected results come from closed-form trig and the ITER-step CORDIC gain, tolerance +/-256 LSB.
module tb_cordic_iter_engine;

    localparam int  WID   = 32;
    localparam int  ITER  = 24;
    localparam int  GUARD = 2;
    localparam int  TOL   = 256;
    localparam real PI    = 3.14159265358979323846;

    logic           clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]     mode;
    logic [WID-1:0] x_in, y_in, z_in, x_out, y_out, z_out;

    int             n_cmp = 0;
    int             n_bad = 0;
    int             r_lat;
    logic [31:0]    r_x, r_y, r_z;
    real            an;

    cordic_iter_engine #(.WID(WID), .ITER(ITER), .GUARD(GUARD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] q30(input real v);
        return 32'(longint'(v * 1073741824.0));
    endfunction

    function automatic logic [31:0] qang(input real rad);
        return 32'(longint'(rad * 2147483648.0 / PI));
    endfunction

    task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
        int diff;
        diff = int'(obs - exp);
        n_cmp++;
        assert (diff <= tol && diff >= -tol) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Issue one operand, wait (bounded) for out_valid, capture results, then one more edge.
    task automatic run_op(input logic [1:0] m, input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] zi);
        @(negedge clk);
        mode = m; x_in = xi; y_in = yi; z_in = zi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        r_lat = 0;
        while (out_valid !== 1'b1 && r_lat < 100) begin
            @(posedge clk); #1;
            r_lat++;
        end
        r_x = x_out; r_y = y_out; r_z = z_out;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        logic [31:0] e_c45, e_an_half, e_vec_mag;
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mode = 2'b00; x_in = '0; y_in = '0; z_in = '0;
        an = 1.0;
        for (int i = 0; i < ITER; i++) an = an * $sqrt(1.0 + 1.0 / (4.0 ** i));
        e_c45     = q30($cos(PI / 4.0));
        e_an_half = q30(0.5 * an);
        e_vec_mag = q30($sqrt(0.5) * an);

        // Reset state
        #12;
        check_bit("rst in_ready", in_ready, 1'b0);
        check_bit("rst out_valid", out_valid, 1'b0);
        check_bit("rst busy", busy, 1'b0);
        check_near("rst x_out", x_out, 32'h0, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_bit("in_ready after release", in_ready, 1'b1);

        // sincos pi/4 with latency and handshake
        run_op(2'b01, 32'h0, 32'h0, 32'h2000_0000);
        check_near("sincos45 latency", 32'(r_lat), 32'd26, 0);
        check_near("sincos45 x", r_x, e_c45, TOL);
        check_near("sincos45 y", r_y, e_c45, TOL);
        check_near("sincos45 z", r_z, 32'h0, TOL);
        check_bit("post-handshake out_valid", out_valid, 1'b0);
        check_bit("post-handshake busy", busy, 1'b0);

        // sincos -pi and 3pi/4 exercise pre-rotation
        run_op(2'b01, 32'h0, 32'h0, 32'h8000_0000);
        check_near("sincos-180 x", r_x, q30(-1.0), TOL);
        check_near("sincos-180 y", r_y, 32'h0, TOL);
        run_op(2'b01, 32'h0, 32'h0, 32'h6000_0000);
        check_near("sincos135 x", r_x, q30(-$cos(PI / 4.0)), TOL);
        check_near("sincos135 y", r_y, e_c45, TOL);

        // rotate (0.5, 0) by pi/2; mode 11 must match mode 00
        run_op(2'b00, 32'h2000_0000, 32'h0, 32'h4000_0000);
        check_near("rot90 x", r_x, 32'h0, TOL);
        check_near("rot90 y", r_y, e_an_half, TOL);
        check_near("rot90 z", r_z, 32'h0, TOL);
        run_op(2'b11, 32'h2000_0000, 32'h0, 32'h4000_0000);
        check_near("mode11 x", r_x, 32'h0, TOL);
        check_near("mode11 y", r_y, e_an_half, TOL);

        // vectoring
        run_op(2'b10, 32'h2000_0000, 32'h2000_0000, 32'h0);
        check_near("vec45 x", r_x, e_vec_mag, TOL);
        check_near("vec45 y", r_y, 32'h0, TOL);
        check_near("vec45 z", r_z, qang(PI / 4.0), TOL);
        run_op(2'b10, 32'hE000_0000, 32'h0, 32'h0);
        check_near("vec180 x", r_x, e_an_half, TOL);
        check_near("vec180 y", r_y, 32'h0, TOL);
        check_near("vec180 z", r_z, qang(PI), TOL);
        run_op(2'b10, 32'h0, 32'h0, 32'h1234_5678);
        check_near("vec0 x", r_x, 32'h0, 0);
        check_near("vec0 y", r_y, 32'h0, 0);
        check_near("vec0 z", r_z, 32'h0, 0);

        // full-scale inputs saturate after the gain
        run_op(2'b00, 32'h7FFF_FFFF, 32'h0, 32'h0);
        check_near("sat pos x", r_x, 32'h7FFF_FFFF, 0);
        run_op(2'b00, 32'h8000_0000, 32'h0, 32'h0);
        check_near("sat neg x", r_x, 32'h8000_0000, 0);

        // Backpressure: result held, second operand refused
        out_ready = 1'b0;
        run_op(2'b01, 32'h0, 32'h0, 32'h2000_0000);
        check_near("bp first x", r_x, e_c45, TOL);
        @(negedge clk);
        mode = 2'b10; x_in = 32'h2000_0000; y_in = 32'h2000_0000; z_in = '0; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check_bit("bp out_valid", out_valid, 1'b1);
            check_bit("bp in_ready", in_ready, 1'b0);
            check_near("bp x", x_out, e_c45, TOL);
            check_near("bp y", y_out, e_c45, TOL);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        check_bit("bp release out_valid", out_valid, 1'b0);
        check_bit("bp second not consumed", busy, 1'b0);
        @(negedge clk); in_valid = 1'b0;

        // Reset in the middle of iterating
        @(negedge clk);
        mode = 2'b01; z_in = 32'h2000_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_bit("abort op accepted", busy, 1'b1);
        repeat (12) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check_bit("abort out_valid", out_valid, 1'b0);
        check_bit("abort busy", busy, 1'b0);
        check_bit("abort in_ready", in_ready, 1'b0);
        check_near("abort x_out cleared", x_out, 32'h0, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_bit("abort in_ready back", in_ready, 1'b1);
        run_op(2'b10, 32'h2000_0000, 32'h2000_0000, 32'h0);
        check_near("post-abort latency", 32'(r_lat), 32'd26, 0);
        check_near("post-abort x", r_x, e_vec_mag, TOL);
        check_near("post-abort z", r_z, qang(PI / 4.0), TOL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
